meas_bcd_scheduler: RTL
=======================

Name: meas_bcd_scheduler

Overview:
- Shares one iterative binary-to-BCD converter between up to four measurement channels (duty, frequency, amplitude, period) that feed the oscilloscope readout.
- Requesters raise a level request. A round-robin arbiter grants one channel, latches its operand, and runs a shift-and-add-3 conversion at one bit per cycle.
- Each result is delivered with a channel tag and a one-cycle valid strobe to the display formatter.

Parameters:
- NCH, 3, number of requesting channels (1..4).
- BIN_W, 20, binary operand width per channel.
- DIG, 6, number of BCD output digits; the result field is 4*DIG bits.

Ports:
- clk_50M  in  1  system clock, 50 MHz.
- rst  in  1  reset, asynchronous, active-low.
- req  in  NCH  per-channel conversion request (level).
- bin_in  in  NCH*BIN_W  channel c operand at bits [c*BIN_W +: BIN_W].
- ack  out  NCH  one-cycle pulse: that channel's operand has been latched.
- bcd_out  out  4*DIG  converted result, digit 0 in bits [3:0].
- bcd_ch  out  2  channel index of bcd_out.
- bcd_valid  out  1  one-cycle strobe: bcd_out, bcd_ch and overflow are updated.
- overflow  out  1  operand exceeded 10^DIG-1.
- busy  out  1  converter occupied (SHIFT or DONE state).

Behaviour:
- Reset is asynchronous, active-low, clock clk_50M. While rst=0:
  - all outputs are 0;
  - state = IDLE, the round-robin pointer is cleared so channel 0 has top priority, and all internal registers are cleared.
- A reset asserted mid-conversion aborts the conversion: no bcd_valid, no partial result visible.
- FSM states are IDLE, SHIFT, DONE.
- IDLE:
  - If any req bit is 1, select the winner: search from (last_grant+1) mod NCH upward, cyclic. After reset the search starts at channel 0.
  - On the next edge: latch bin_in of the winner into the operand shift register, clear the BCD accumulator and the overflow flag, set count = BIN_W, record the winner as bcd channel and last_grant, pulse ack[winner] for exactly one cycle, go to SHIFT.
  - If no req is set, remain in IDLE.
- SHIFT, once per cycle:
  - Every 4-bit accumulator digit that is ≥5 gets +3 added, all digits in parallel.
  - Then shift {accumulator, operand} left by 1.
  - If the bit shifted out of the top of the accumulator is 1, set the sticky overflow flag.
  - Decrement count. When count reaches 1 on this cycle, go to DONE next.
  - Exactly BIN_W SHIFT cycles are executed.
- DONE, one cycle:
  - Register bcd_out = accumulator, or all digits 9 if the overflow flag is set.
  - Register bcd_ch and overflow, pulse bcd_valid.
  - Go to IDLE unconditionally.
- Latency: ack is high in the first SHIFT cycle (cycle 1). bcd_valid is high in cycle BIN_W+1. The next ack comes no earlier than cycle BIN_W+2, so throughput is one conversion per BIN_W+2 cycles.
- bcd_out, bcd_ch and overflow hold their values between strobes. busy = 1 in SHIFT and DONE, 0 in IDLE.
- Zero operand: converted normally, giving bcd_out = 0 and a valid strobe. Zero is not skipped.
- Request and operand timing:
  - Dropping req or changing bin_in after ack has no effect on the running conversion.
  - If req is still high after ack, the channel is served again in its round-robin turn with the then-current bin_in.
  - A req that rises during SHIFT or DONE is arbitrated in the next IDLE cycle.
- Simultaneous requests: exactly one ack bit per grant; no channel waits more than NCH grants.
- Channels ≥ NCH do not exist. bcd_ch is zero-extended to 2 bits.

Test Plan:
- Single request, req[0]=1 with value 50, released after ack → ack[0] pulse in cycle 1; bcd_valid in cycle 21 with bcd_out=0x000050, bcd_ch=0, overflow=0.
- Boundary operands on ch1:
  - 999999 → 0x999999, overflow=0.
  - 1000000 → 0x999999, overflow=1.
  - 1048575 → 0x999999, overflow=1.
  - Next conversion of 123456 → 0x123456, overflow=0.
- Zero operand on ch2 → bcd_valid pulse with bcd_out=0x000000, bcd_ch=2.
- req=3'b111 held from reset release → grants in order 0,1,2,0,1,2; valid strobes 22 cycles apart; each ack a single cycle with exactly one bit set.
- ch1 is busy converting 777; its req drops and bin_in changes mid-SHIFT, and req[2] rises → result is 0x000777, ch=1; then ch2 is granted in the following IDLE cycle.
- rst=0 asserted in SHIFT cycle 10 → all outputs 0 immediately and no bcd_valid. After release with req[1] and req[0] held → ch0 is granted first, with full 21-cycle latency.

Source files
------------

// File: rtl/meas_bcd_scheduler.sv
// meas_bcd_scheduler
// Shares one iterative shift-and-add-3 binary-to-BCD converter between up to
// four measurement channels (duty, frequency, amplitude, period) that feed the
// oscilloscope readout. A round-robin arbiter picks one requesting channel,
// latches its operand and converts it at one bit per clock. The result is
// delivered with its channel tag and a one-cycle valid strobe.
//
// Ports:
//   clk_50M    in   1          system clock
//   rst        in   1          asynchronous reset, active-low
//   req        in   NCH        per-channel conversion request (level)
//   bin_in     in   NCH*BIN_W  channel c operand at [c*BIN_W +: BIN_W]
//   ack        out  NCH        one-cycle pulse: that channel's operand was latched
//   bcd_out    out  4*DIG      converted result, digit 0 in [3:0]
//   bcd_ch     out  2          channel index of bcd_out
//   bcd_valid  out  1          one-cycle strobe: bcd_out/bcd_ch/overflow updated
//   overflow   out  1          operand exceeded 10^DIG-1
//   busy       out  1          converter occupied (SHIFT or DONE)
module meas_bcd_scheduler #(
    parameter int NCH   = 3,
    parameter int BIN_W = 20,
    parameter int DIG   = 6
) (
    input  logic                   clk_50M,
    input  logic                   rst,
    input  logic [NCH-1:0]         req,
    input  logic [NCH*BIN_W-1:0]   bin_in,
    output logic [NCH-1:0]         ack,
    output logic [4*DIG-1:0]       bcd_out,
    output logic [1:0]             bcd_ch,
    output logic                   bcd_valid,
    output logic                   overflow,
    output logic                   busy
);

    localparam int ACC_W = 4 * DIG;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t             state;
    logic [1:0]         rr_ptr;
    logic [1:0]         cur_ch;
    logic [1:0]         winner;
    logic [2:0]         cand;
    logic               found;
    logic [BIN_W-1:0]   operand;
    logic [BIN_W-1:0]   operand_next;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   acc_adj;
    logic [ACC_W-1:0]   acc_next;
    logic               ovf_flag;
    logic               ovf_next;
    logic [CNT_W-1:0]   count;
    logic [BIN_W-1:0]   chan_op [NCH];

    // Split the packed operand bus into one word per channel.
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            chan_op[c] = bin_in[c*BIN_W +: BIN_W];
        end
    end

    // Round-robin search: rr_ptr holds the channel with top priority
    // (one past the last grant), scanning upward with wrap-around.
    always_comb begin
        found  = 1'b0;
        winner = 2'd0;
        cand   = 3'd0;
        for (int k = 0; k < NCH; k++) begin
            cand = {1'b0, rr_ptr} + 3'(k);
            if (cand >= 3'(NCH)) begin
                cand = cand - 3'(NCH);
            end
            if (!found && req[cand[1:0]]) begin
                found  = 1'b1;
                winner = cand[1:0];
            end
        end
    end

    // One double-dabble step: correct every digit >= 5 in parallel, then
    // shift {acc, operand} left. Any 1 falling off the top of the
    // accumulator means the value needs more than DIG digits.
    always_comb begin
        acc_adj = acc;
        for (int d = 0; d < DIG; d++) begin
            if (acc[4*d +: 4] >= 4'd5) begin
                acc_adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
            end
        end
        acc_next     = {acc_adj[ACC_W-2:0], operand[BIN_W-1]};
        operand_next = {operand[BIN_W-2:0], 1'b0};
        ovf_next     = ovf_flag | acc_adj[ACC_W-1];
    end

    assign busy = (state != IDLE);

    // Main FSM. Result registers are loaded on the last SHIFT edge so the
    // strobe is visible during the DONE cycle itself.
    always_ff @(posedge clk_50M or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            rr_ptr    <= 2'd0;
            cur_ch    <= 2'd0;
            operand   <= '0;
            acc       <= '0;
            ovf_flag  <= 1'b0;
            count     <= '0;
            ack       <= '0;
            bcd_out   <= '0;
            bcd_ch    <= 2'd0;
            bcd_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            ack       <= '0;
            bcd_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        operand  <= chan_op[winner];
                        acc      <= '0;
                        ovf_flag <= 1'b0;
                        count    <= CNT_W'(BIN_W);
                        cur_ch   <= winner;
                        rr_ptr   <= (winner == 2'(NCH - 1)) ? 2'd0 : winner + 2'd1;
                        ack      <= NCH'(1'b1) << winner;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc      <= acc_next;
                    operand  <= operand_next;
                    ovf_flag <= ovf_next;
                    count    <= count - 1'b1;
                    if (count == CNT_W'(1)) begin
                        bcd_out   <= ovf_next ? {DIG{4'h9}} : acc_next;
                        bcd_ch    <= cur_ch;
                        overflow  <= ovf_next;
                        bcd_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
